// File: rtl/bus_pkg.sv
// Shared bus map: peripheral base addresses, timer register offsets, TCON bit positions.
// Pure constants, no logic.
package bus_pkg;
    localparam int          DATA_W            = 32;
    localparam logic [31:0] TIMER_BASE_ADDR   = 32'h4000_0000;

    localparam logic [3:0]  TIMER_TH_OFF      = 4'h0;
    localparam logic [3:0]  TIMER_TL_OFF      = 4'h4;
    localparam logic [3:0]  TIMER_TCON_OFF    = 4'h8;
    localparam logic [3:0]  TIMER_SYSTICK_OFF = 4'hC;

    localparam int          TCON_EN           = 0;
    localparam int          TCON_IE           = 1;
    localparam int          TCON_IRQ          = 2;
endpackage

// File: rtl/timer_prescaler.sv
// Prescaler: divides clk by PRESCALE while enabled; the count holds (not cleared) while disabled.
// Tick is combinational from the held count; no backpressure.
module timer_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);
    localparam logic [15:0] LAST = 16'(PRESCALE - 1);

    logic [15:0] pre_cnt;

    assign tick = en && (pre_cnt == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre_cnt <= '0;
        end else if (en) begin
            pre_cnt <= tick ? 16'h0 : pre_cnt + 16'h1;
        end
    end
endmodule

// File: rtl/bus_timer.sv
// Memory-mapped reloadable count-up timer on the MEM-stage data bus; zero-latency reads, writes at clk edge.
// Optional free-running SYSTICK at +0xC when TIMER_SYSTICK_EN is defined; no backpressure.
module bus_timer
    import bus_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = TIMER_BASE_ADDR,
    parameter int          PRESCALE  = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         addr,
    input  logic                mem_rd,
    input  logic                mem_wr,
    input  logic [DATA_W-1:0]   wr_data,
    output logic [DATA_W-1:0]   rd_data,
    output logic                sel,
    output logic                irq
);
    logic [DATA_W-1:0] th;
    logic [DATA_W-1:0] tl;
    logic              en;
    logic              ie;
    logic              ip;

    logic [31:0] word_addr;
    logic [31:0] rel_addr;
    logic [3:0]  off;
    logic        wr_th, wr_tl, wr_tcon;
    logic        tick, ovf, irq_set;

    assign word_addr = {addr[31:2], 2'b00};
    assign rel_addr  = word_addr - BASE_ADDR;
    assign sel       = (word_addr >= BASE_ADDR) && (rel_addr[31:4] == 28'h0);
    assign off       = rel_addr[3:0];

    assign wr_th   = mem_wr && sel && (off == TIMER_TH_OFF);
    assign wr_tl   = mem_wr && sel && (off == TIMER_TL_OFF);
    assign wr_tcon = mem_wr && sel && (off == TIMER_TCON_OFF);

    timer_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .tick  (tick)
    );

    // A CPU write to TL in the overflow cycle suppresses both reload and IRQ.
    assign ovf     = tick && (tl == '1);
    assign irq_set = ovf && ie && !wr_tl;
    assign irq     = ip;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            th <= '0;
            tl <= '0;
            en <= 1'b0;
            ie <= 1'b0;
            ip <= 1'b0;
        end else begin
            if (wr_th) th <= wr_data;
            if (wr_tl) begin
                tl <= wr_data;
            end else if (tick) begin
                tl <= ovf ? th : tl + 1'b1;
            end
            if (wr_tcon) begin
                en <= wr_data[TCON_EN];
                ie <= wr_data[TCON_IE];
            end
            if (irq_set) begin
                ip <= 1'b1;
            end else if (wr_tcon && !wr_data[TCON_IRQ]) begin
                ip <= 1'b0;
            end
        end
    end

`ifdef TIMER_SYSTICK_EN
    logic [DATA_W-1:0] systick;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) systick <= '0;
        else        systick <= systick + 1'b1;
    end
`endif

    always_comb begin
        rd_data = '0;
        if (mem_rd && sel) begin
            case (off)
                TIMER_TH_OFF:      rd_data = th;
                TIMER_TL_OFF:      rd_data = tl;
                TIMER_TCON_OFF:    rd_data = {{(DATA_W-3){1'b0}}, ip, ie, en};
`ifdef TIMER_SYSTICK_EN
                TIMER_SYSTICK_OFF: rd_data = systick;
`endif
                default:           rd_data = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_bus_timer.sv
// Randomized + directed bench for bus_timer with a cycle-level reference model and a scoreboard queue.
module tb_bus_timer;
    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam int          P    = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] addr = '0;
    logic        mem_rd = 1'b0;
    logic        mem_wr = 1'b0;
    logic [31:0] wr_data = '0;
    logic [31:0] rd_data;
    logic        sel;
    logic        irq;

    bus_timer #(.BASE_ADDR(BASE), .PRESCALE(P)) dut (
        .clk     (clk),
        .reset   (reset),
        .addr    (addr),
        .mem_rd  (mem_rd),
        .mem_wr  (mem_wr),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .sel     (sel),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rd;
        logic        sel;
        logic        irq;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    bit   done  = 0;

    // Reference model: architectural state only.
    logic [31:0] m_th, m_tl, m_st;
    bit          m_en, m_ie, m_ip;
    int          m_pc;

    function automatic bit in_win(input logic [31:0] a);
        longint w;
        w = longint'({a[31:2], 2'b00});
        return (w >= longint'(BASE)) && (w < longint'(BASE) + 16);
    endfunction

    function automatic int reg_idx(input logic [31:0] a);
        return int'(({a[31:2], 2'b00} - BASE) >> 2);
    endfunction

    function automatic logic [31:0] model_read(input logic r, input logic [31:0] a);
        if (!r || !in_win(a)) return 32'h0;
        case (reg_idx(a))
            0: return m_th;
            1: return m_tl;
            2: return {29'h0, m_ip, m_ie, m_en};
`ifdef TIMER_SYSTICK_EN
            3: return m_st;
`endif
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_zero();
        m_th = 0; m_tl = 0; m_st = 0; m_en = 0; m_ie = 0; m_ip = 0; m_pc = 0;
    endtask

    task automatic model_edge(input logic w, input logic [31:0] a, input logic [31:0] d);
        bit tick, ovf, w_th, w_tl, w_tc;
        w_th = w && in_win(a) && reg_idx(a) == 0;
        w_tl = w && in_win(a) && reg_idx(a) == 1;
        w_tc = w && in_win(a) && reg_idx(a) == 2;
        tick = m_en && (m_pc == P - 1);
        ovf  = tick && (m_tl == 32'hFFFF_FFFF);
        if (m_en) m_pc = tick ? 0 : m_pc + 1;
        if (w_tl)       m_tl = d;
        else if (ovf)   m_tl = m_th;
        else if (tick)  m_tl = m_tl + 1;
        if (ovf && m_ie && !w_tl) m_ip = 1;
        else if (w_tc && !d[2])   m_ip = 0;
        if (w_th) m_th = d;
        if (w_tc) begin
            m_en = d[0];
            m_ie = d[1];
        end
        m_st = m_st + 1;
    endtask

    task automatic cyc(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        @(posedge clk);
        #1;
        reset = 1'b1; mem_wr = w; mem_rd = r; addr = a; wr_data = d;
        e.rd = model_read(r, a); e.sel = in_win(a); e.irq = m_ip;
        q.push_back(e);
        model_edge(w, a, d);
    endtask

    task automatic rst_cyc(input logic [31:0] a);
        exp_t e;
        @(posedge clk);
        #1;
        reset = 1'b0; mem_wr = 1'b1; mem_rd = 1'b1; addr = a; wr_data = 32'h1234_5678;
        model_zero();
        e.rd = model_read(1'b1, a); e.sel = in_win(a); e.irq = 1'b0;
        q.push_back(e);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d); cyc(1'b1, 1'b0, a, d); endtask
    task automatic rd(input logic [31:0] a);                       cyc(1'b0, 1'b1, a, 32'h0); endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h at %0t", nm, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("rd_data", rd_data, e.rd);
            chk("sel", {31'h0, sel}, {31'h0, e.sel});
            chk("irq", {31'h0, irq}, {31'h0, e.irq});
        end
    end

    // Drive the model to the cycle just before a prescaler tick.
    task automatic wait_tick_edge();
        for (int i = 0; i < 3 * P; i++) begin
            if (m_en && m_pc == P - 1) return;
            rd(BASE + 32'h4);
        end
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 7))
            0: return BASE;
            1: return BASE + 32'h4;
            2, 3: return BASE + 32'h8;
            4: return BASE + 32'hC;
            5: return BASE + 32'h10;
            6: return BASE - 32'h4 + 32'($urandom_range(0, 3));
            default: return BASE + 32'($urandom_range(0, 15));
        endcase
    endfunction

    initial begin
        logic [31:0] a, d;
        model_zero();
        rst_cyc(BASE + 32'h4);
        rst_cyc(BASE + 32'h8);

        // Reset mid-count.
        wr(BASE + 32'h4, 32'h5);
        wr(BASE + 32'h8, 32'h1);
        for (int i = 0; i < 6; i++) rd(BASE + 32'h4);
        rst_cyc(BASE + 32'h4);
        rd(BASE + 32'h8);
        wr(BASE, 32'h10);
        rd(BASE);

        // Overflow, reload, IRQ, software clear.
        wr(BASE, 32'hFFFF_FFF0);
        wr(BASE + 32'h4, 32'hFFFF_FFFE);
        wr(BASE + 32'h8, 32'h3);
        for (int i = 0; i < 12; i++) rd(BASE + 32'h4);
        rd(BASE + 32'h8);
        wr(BASE + 32'h8, 32'h3);
        rd(BASE + 32'h8);
        rd(BASE + 32'h8);

        // Prescaler pause/resume.
        wr(BASE + 32'h8, 32'h0);
        wr(BASE + 32'h4, 32'h0);
        wr(BASE + 32'h8, 32'h1);
        for (int i = 0; i < 11; i++) rd(BASE + 32'h4);
        wr(BASE + 32'h8, 32'h0);
        for (int i = 0; i < 5; i++) rd(BASE + 32'h4);
        wr(BASE + 32'h8, 32'h1);
        for (int i = 0; i < 6; i++) rd(BASE + 32'h4);

        // Collision: TL write on the overflow tick.
        wr(BASE + 32'h8, 32'h0);
        wr(BASE + 32'h4, 32'hFFFF_FFFF);
        wr(BASE + 32'h8, 32'h3);
        wait_tick_edge();
        wr(BASE + 32'h4, 32'h100);
        rd(BASE + 32'h4);
        rd(BASE + 32'h8);

        // Collision: software IRQ clear on an overflow tick with IE set.
        wr(BASE + 32'h8, 32'h0);
        wr(BASE + 32'h4, 32'hFFFF_FFFF);
        wr(BASE + 32'h8, 32'h3);
        wait_tick_edge();
        wr(BASE + 32'h8, 32'h3);
        rd(BASE + 32'h8);
        rd(BASE + 32'h4);

        // Address decode.
        rd(BASE + 32'h10);
        wr(BASE + 32'hB, 32'h0);
        rd(BASE + 32'h8);
        wr(BASE - 32'h4, 32'hDEAD_BEEF);
        rd(BASE); rd(BASE + 32'h4); rd(BASE + 32'h8);
        cyc(1'b1, 1'b1, BASE, 32'hCAFE_0001);
        rd(BASE);

        // SYSTICK.
        rd(BASE + 32'hC);
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, BASE + 32'h20, 32'h0);
        rd(BASE + 32'hC);
        wr(BASE + 32'hC, 32'h0);
        rd(BASE + 32'hC);

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                rst_cyc(rand_addr());
            end else begin
                a = rand_addr();
                d = $urandom;
                if (reg_idx(a) == 1 && $urandom_range(0, 1) == 1)
                    d = 32'hFFFF_FFFF - 32'($urandom_range(0, 12));
                if (reg_idx(a) == 2 && $urandom_range(0, 3) != 0)
                    d = {29'h0, d[2:1], 1'b1};
                cyc(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)), a, d);
            end
        end

        cyc(1'b0, 1'b0, 32'h0, 32'h0);
        done = 1;
        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", 32'(q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout expected=completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/bus_timer.md
Name: bus_timer

Overview:
- Memory-mapped timer peripheral attached to the data-memory bus that the pipeline's MEM stage drives (address = EX/MEM ALU result; rd/wr strobes and write data come from EX/MEM).
- Consumes MEM-stage load/store traffic.
- Provides a reloadable count-up timer with an interrupt request line toward the control path.
- Read data returns combinationally in the same cycle, so the MEM/WB register captures it like data-memory output.

Parameters:
- BASE_ADDR, 32'h4000_0000, word address of register block (TH at +0x0, TL +0x4, TCON +0x8, SYSTICK +0xC)
- PRESCALE, 1, clock cycles per timer tick (1..65535); 1 = tick every cycle

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset)
- addr  input  32  byte address from EX/MEM ALU result; bits [1:0] ignored
- mem_rd  input  1  load strobe
- mem_wr  input  1  store strobe
- wr_data  input  32  store data (EX/MEM rt data)
- rd_data  output  32  read data, combinational
- sel  output  1  addr in [BASE_ADDR, BASE_ADDR+0xF]; used by Bus to mux rd_data
- irq  output  1  interrupt request = TCON[2]

Behaviour:
- Registers:
  - TH[31:0]: reload value.
  - TL[31:0]: counter.
  - TCON[2:0]: bit0 EN, bit1 IE, bit2 IRQ status.
  - pre_cnt[15:0]: internal prescaler.
- Reset (reset=0, async): TH=0, TL=0, TCON=0, pre_cnt=0, SYSTICK=0. irq=0. rd_data follows the read mux, which yields 0 with all registers 0.
- Reads:
  - rd_data = selected register when mem_rd && sel, else 32'h0.
  - TCON reads zero-extended.
  - Unmapped offset inside the window reads 0.
  - Zero-cycle latency.
- Writes: take effect at the clk edge when mem_wr && sel. Writes to read-only or unmapped offsets are ignored.
- Tick:
  - tick = EN && (pre_cnt == PRESCALE-1).
  - When EN=1, pre_cnt increments and wraps to 0 on tick.
  - When EN=0, pre_cnt holds and TL holds.
- Counting:
  - On tick with TL != 32'hFFFF_FFFF: TL <= TL+1.
  - On tick with TL == 32'hFFFF_FFFF: TL <= TH (overflow), and if IE then TCON[2] <= 1.
  - Overflow is a 2-state sequence COUNT → RELOAD → COUNT only in the sense of data. No extra cycle: reload happens on the overflow tick itself.
- Write to TL in the same cycle as a tick: CPU write wins; no increment, no reload, no IRQ set that cycle.
- Write to TH in the same cycle as an overflow: reload uses the OLD TH; the new TH applies from the next overflow.
- Write to TCON:
  - EN and IE are written directly.
  - TCON[2] is cleared only by writing 0 to bit 2; writing 1 to bit 2 has no effect (software cannot set).
  - If a hardware IRQ set and a software clear occur in the same cycle, the hardware set wins (TCON[2]=1).
- Clearing EN: pre_cnt is NOT reset. Resuming continues the partial prescale.
- irq is a registered level: it rises the cycle after the overflow edge and stays high until software clears it.
- mem_rd and mem_wr both high: the write is performed and rd_data shows the pre-write value.

Optional Feature:
- Macro: TIMER_SYSTICK_EN.
- Defined: offset +0xC is SYSTICK.
  - 32-bit free-running count incremented every clk regardless of EN, wrapping FFFF_FFFF→0.
  - Read-only; writes are ignored.
- Undefined: SYSTICK register is absent; +0xC reads 0 and writes are ignored.

Decomposition:
- Shared package bus_pkg:
  - Peripheral base addresses and register offsets (TIMER_TH_OFF, TIMER_TL_OFF, TIMER_TCON_OFF, TIMER_SYSTICK_OFF).
  - TCON bit indices (TCON_EN, TCON_IE, TCON_IRQ).
  - Data width constant.
- Sub-module timer_prescaler: pre_cnt register with en input and tick output, parameterised by PRESCALE.
- All remaining logic, including the register file and read mux, stays in bus_timer.

Test Plan:
1. Reset and register readback:
   - Stimulus: hold reset=0 mid-count with EN=1 and TL=5, then release.
   - Required: TL=0, TCON=0, irq=0 immediately (async).
   - Stimulus: write TH=0x10, then read TH.
   - Required: reads 0x10.
2. Overflow with reload and IRQ (PRESCALE=1):
   - Stimulus: TH=0xFFFF_FFF0, TL=0xFFFF_FFFE, TCON=3'b011.
   - Required: after 2 cycles TL=0xFFFF_FFF0, and irq=1 on the next cycle.
   - Stimulus: write TCON=3'b011.
   - Required: irq=0 next cycle.
3. Prescaler (PRESCALE=4):
   - Stimulus: TL=0, EN=1, run 12 cycles.
   - Required: TL=3.
   - Stimulus: clear EN for 5 cycles.
   - Required: TL stays 3.
   - Stimulus: set EN again.
   - Required: the prescale phase resumes, not restarted.
4. Collisions:
   - Stimulus: write TL=0x100 on the same edge as an overflow tick with IE=1.
   - Required: TL=0x100 and irq stays 0.
   - Stimulus: software clear of TCON[2] on an overflow edge.
   - Required: irq stays 1.
5. Address decode:
   - Stimulus: read BASE_ADDR+0x10.
   - Required: sel=0, rd_data=0.
   - Stimulus: write to the TCON offset with addr[1:0]=2'b11.
   - Required: decoded as TCON.
   - Stimulus: store to BASE_ADDR-4.
   - Required: no register changes.
6. SYSTICK:
   - With TIMER_SYSTICK_EN defined: two reads 7 cycles apart differ by 7, and a write does not change SYSTICK.
   - Without the macro: +0xC reads 0.
